// File: rtl/pingpong_vector_mem_if.sv
// Producer stream and consumer read-window signals of the ping-pong vector store.
interface pingpong_vector_mem_if #(
   parameter int WIDTH   = 16,
   parameter int LOGSIZE = 6,
   parameter int LANES   = 8
);
   logic signed [WIDTH-1:0] s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic                    s_last;
   logic                    rd_valid;
   logic [LOGSIZE:0]        rd_len;
   logic [LOGSIZE-1:0]      rd_addr;
   logic signed [WIDTH-1:0] rd_data [LANES-1:0];
   logic                    rd_release;

   // Producer and consumer side (drives the write stream and read window address)
   modport master (
      output s_data, s_valid, s_last, rd_addr, rd_release,
      input  s_ready, rd_valid, rd_len, rd_data
   );

   // Memory side
   modport slave (
      input  s_data, s_valid, s_last, rd_addr, rd_release,
      output s_ready, rd_valid, rd_len, rd_data
   );
endinterface

// File: rtl/pingpong_vector_mem.sv
// Double-buffered X/F operand vector store: one bank loads from the producer
// stream while the consumer reads a LANES-wide window from the other bank.
module pingpong_vector_mem #(
   parameter int WIDTH   = 16,
   parameter int SIZE    = 64,
   parameter int LOGSIZE = 6,
   parameter int LANES   = 8
) (
   input logic                   clk,
   input logic                   reset,
   pingpong_vector_mem_if.slave  bus
);

   logic signed [WIDTH-1:0] mem [2][SIZE];
   logic [1:0]              full;
   logic [LOGSIZE:0]        len [2];
   logic                    wr_bank;
   logic                    rd_bank;
   logic [LOGSIZE-1:0]      wr_ptr;

   logic                    s_ready_int;
   logic                    rd_valid_int;
   logic [LOGSIZE:0]        rd_len_int;
   logic                    accept;
   logic                    complete;
   logic                    release_ok;
   logic [LOGSIZE:0]        idx [LANES];

   // Handshake and status decode; s_ready depends only on registers and reset
   always_comb begin
      s_ready_int  = ~reset & ~full[wr_bank];
      rd_valid_int = ~reset & full[rd_bank];
      rd_len_int   = rd_valid_int ? len[rd_bank] : '0;
      accept       = bus.s_valid & s_ready_int;
      complete     = accept & (bus.s_last | (wr_ptr == LOGSIZE'(SIZE - 1)));
      release_ok   = bus.rd_release & rd_valid_int;
      bus.s_ready  = s_ready_int;
      bus.rd_valid = rd_valid_int;
      bus.rd_len   = rd_len_int;
   end

   // Storage write; contents are not reset, full flags guard their visibility
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_bank][wr_ptr] <= bus.s_data;
      end
   end

   // Bank bookkeeping: completion and release may coincide, always on different banks
   always_ff @(posedge clk) begin
      if (reset) begin
         full    <= '0;
         len[0]  <= '0;
         len[1]  <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_ptr  <= '0;
      end else begin
         if (accept) begin
            if (complete) begin
               full[wr_bank] <= 1'b1;
               len[wr_bank]  <= (LOGSIZE+1)'(wr_ptr) + (LOGSIZE+1)'(1);
               wr_ptr        <= '0;
               wr_bank       <= ~wr_bank;
            end else begin
               wr_ptr <= wr_ptr + LOGSIZE'(1);
            end
         end
         if (release_ok) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   // Read window: index sum is one bit wider so lanes past the vector end read zero
   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         idx[i]         = (LOGSIZE+1)'(bus.rd_addr) + (LOGSIZE+1)'(i);
         bus.rd_data[i] = '0;
         if (rd_valid_int && (idx[i] < rd_len_int)) begin
            bus.rd_data[i] = mem[rd_bank][idx[i][LOGSIZE-1:0]];
         end
      end
   end

endmodule

// File: tb/tb_pingpong_vector_mem.sv
// Scoreboard bench for pingpong_vector_mem: the reference model keeps completed
// vectors in a FIFO; every cycle an expectation is queued and a negedge monitor checks it.
module tb_pingpong_vector_mem;
   localparam int WIDTH   = 16;
   localparam int SIZE    = 64;
   localparam int LOGSIZE = 6;
   localparam int LANES   = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pingpong_vector_mem_if #(.WIDTH(WIDTH), .LOGSIZE(LOGSIZE), .LANES(LANES)) bus ();

   pingpong_vector_mem #(.WIDTH(WIDTH), .SIZE(SIZE), .LOGSIZE(LOGSIZE), .LANES(LANES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      int                       cyc;
      logic                     ready;
      logic                     valid;
      logic [LOGSIZE:0]         len;
      logic [LANES*WIDTH-1:0]   data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model: FIFO of completed vectors (lengths + concatenated words), partial vector
   int fifo_len[$];
   int fifo_data[$];
   int part[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t expect_now();
      exp_t e;
      int   a;
      e     = '0;
      e.cyc = cyc;
      if (!reset) begin
         e.ready = (fifo_len.size() < 2);
         if (fifo_len.size() > 0) begin
            e.valid = 1'b1;
            e.len   = (LOGSIZE+1)'(fifo_len[0]);
            for (int i = 0; i < LANES; i++) begin
               a = int'(bus.rd_addr) + i;
               if (a < fifo_len[0]) e.data[i*WIDTH +: WIDTH] = WIDTH'(fifo_data[a]);
            end
         end
      end
      return e;
   endfunction

   // Queue this cycle's expectation, advance the model with this cycle's inputs, then clock
   task automatic step(output bit acc);
      bit rel;
      int n;
      exp_q.push_back(expect_now());
      acc = 1'b0;
      if (reset) begin
         fifo_len.delete();
         fifo_data.delete();
         part.delete();
      end else begin
         rel = bus.rd_release && (fifo_len.size() > 0);
         acc = bus.s_valid && (fifo_len.size() < 2);
         if (rel) begin
            n = fifo_len.pop_front();
            repeat (n) void'(fifo_data.pop_front());
         end
         if (acc) begin
            part.push_back(int'($signed(bus.s_data)));
            if (bus.s_last || part.size() == SIZE) begin
               fifo_len.push_back(part.size());
               foreach (part[k]) fifo_data.push_back(part[k]);
               part.delete();
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      bit a;
      step(a);
   endtask

   task automatic send(input int val, input bit last, input int max_bubble);
      bit acc;
      repeat ($urandom_range(max_bubble, 0)) begin
         bus.s_valid = 1'b0;
         tick();
      end
      bus.s_valid = 1'b1;
      bus.s_data  = WIDTH'(val);
      bus.s_last  = last;
      acc = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step(acc);
         if (acc) break;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: word %0d not accepted within 40 cycles, required acceptance", val);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic release_bank();
      bus.rd_release = 1'b1;
      tick();
      bus.rd_release = 1'b0;
   endtask

   task automatic read(input int addr);
      bus.rd_addr = LOGSIZE'(addr);
      tick();
   endtask

   // Monitor: compare the DUT outputs against the expectation queued for this cycle
   always @(negedge clk) begin
      exp_t                   e;
      logic [LANES*WIDTH-1:0] act;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL stale_expect: cycle %0d expectation never compared, required compare at that cycle", e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         for (int i = 0; i < LANES; i++) act[i*WIDTH +: WIDTH] = bus.rd_data[i];
         checks++;
         if (bus.s_ready !== e.ready || bus.rd_valid !== e.valid ||
             bus.rd_len !== e.len || act !== e.data) begin
            errors++;
            $display("FAIL window cyc=%0d got ready=%0b valid=%0b len=%0d data=%h required ready=%0b valid=%0b len=%0d data=%h",
                     cyc, bus.s_ready, bus.rd_valid, bus.rd_len, act, e.ready, e.valid, e.len, e.data);
         end
      end
   end

   initial begin
      bit        acc;
      bit [15:0] w;
      reset          = 1'b1;
      bus.s_valid    = 1'b0;
      bus.s_data     = '0;
      bus.s_last     = 1'b0;
      bus.rd_addr    = '0;
      bus.rd_release = 1'b0;
      @(posedge clk);
      #1;
      tick();
      tick();
      reset = 1'b0;

      // Full-length vector 1..64 with no s_last
      for (int v = 1; v <= SIZE; v++) send(v, 1'b0, 0);
      read(56);
      read(0);
      release_bank();

      // Short vector with zero-padded tail
      send(-3, 1'b0, 0);
      send(7, 1'b0, 0);
      send(2, 1'b0, 0);
      send(0, 1'b0, 0);
      send(9, 1'b1, 0);
      read(2);
      read(0);
      release_bank();

      // Ping-pong: A then B fill both banks, producer holds a word until a release
      for (int v = 0; v < 3; v++) send(20 + v, v == 2, 0);
      for (int v = 0; v < 4; v++) send(30 + v, v == 3, 0);
      bus.s_valid = 1'b1;
      bus.s_data  = WIDTH'(100);
      bus.s_last  = 1'b0;
      tick();
      tick();
      tick();
      bus.rd_release = 1'b1;
      tick();
      bus.rd_release = 1'b0;
      send(100, 1'b0, 0);
      send(101, 1'b1, 0);

      // Completion and release in the same cycle
      release_bank();
      send(11, 1'b0, 0);
      send(12, 1'b0, 0);
      bus.rd_release = 1'b1;
      send(13, 1'b1, 0);
      bus.rd_release = 1'b0;
      read(0);
      read(1);

      // Release with nothing readable, then a 10-word load with bubbles
      release_bank();
      release_bank();
      tick();
      for (int v = 0; v < 10; v++) send(int'($urandom_range(2000, 0)) - 1000, v == 9, 2);
      read(0);
      read(3);
      read(7);

      // Reset mid-load while the other bank is full
      for (int v = 0; v < 30; v++) send(200 + v, 1'b0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int v = 0; v < 4; v++) send(-50 + v, v == 3, 0);
      read(0);
      read(2);

      // Randomised traffic honouring the hold-until-accepted producer rule
      for (int n = 0; n < 400; n++) begin
         if (!bus.s_valid && $urandom_range(2, 0) == 0) begin
            w           = 16'($urandom);
            bus.s_valid = 1'b1;
            bus.s_data  = w;
            bus.s_last  = ($urandom_range(7, 0) == 0);
         end
         bus.rd_release = ($urandom_range(5, 0) == 0);
         bus.rd_addr    = LOGSIZE'($urandom_range(SIZE - 1, 0));
         reset          = ($urandom_range(199, 0) == 0);
         step(acc);
         if (acc) begin
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
         end
      end
      reset          = 1'b0;
      bus.s_valid    = 1'b0;
      bus.rd_release = 1'b0;
      tick();

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left uncompared, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
